// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and constants for the SPI responder.
//   spi_slave_state_t : frame state (IDLE between frames, SHIFT while selected)
//   CPOL_LEAD_RISE/FALL : CPOL value -> which synced SCLK edge is the leading one
package spi_slave_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_slave_state_t;

    localparam bit CPOL_LEAD_RISE = 1'b0;  // idle low, sample on rise
    localparam bit CPOL_LEAD_FALL = 1'b1;  // idle high, sample on fall

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: fabric-side word interface of the SPI responder.
//   tx_valid/tx_ready/tx_data : word offered for transmission (valid/ready)
//   rx_valid/rx_data          : one-cycle pulse when rx_data takes a new word
//   busy                      : responder is inside a selected frame
//   underrun                  : one-cycle pulse, FILL word was loaded
// Modports: master = fabric user, slave = spi_slave.
interface spi_slave_if #(
    parameter int DWIDTH = 32
);
    logic              tx_valid;
    logic              tx_ready;
    logic [DWIDTH-1:0] tx_data;
    logic              rx_valid;
    logic [DWIDTH-1:0] rx_data;
    logic              busy;
    logic              underrun;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, rx_valid, rx_data, busy, underrun
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, rx_valid, rx_data, busy, underrun
    );
endinterface

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SYNC_STAGES-flop synchronizer for one async pin plus one
// extra flop for edge detection.
//   clk, reset : fabric clock, synchronous active-high reset
//   d          : async input pin
//   rise, fall : one-cycle pulses on synced edges (SYNC_STAGES+1 clk after pin)
// After reset the chain holds RST_VAL, not the pin; edges are masked until the
// whole chain has been refilled from the pin so a pin that is already at the
// non-idle level does not look like a fresh edge.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;
    logic [SYNC_STAGES:0]   vld_pipe;
    logic                   q;

    assign q = chain[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            chain    <= {SYNC_STAGES{RST_VAL}};
            prev     <= RST_VAL;
            vld_pipe <= '0;
        end else begin
            chain    <= {chain[SYNC_STAGES-2:0], d};
            prev     <= q;
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign rise = vld_pipe[SYNC_STAGES] &  q & ~prev;
    assign fall = vld_pipe[SYNC_STAGES] & ~q &  prev;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI responder, CPHA=0, CPOL by parameter, single fabric clock.
//   clk, reset    : fabric clock (>= 4x SCLK), synchronous active-high reset
//   spi_sclk/ss_n/mosi : async pins from the master, oversampled
//   spi_miso      : serial data out, MSB first
//   spi_miso_oe   : pad enable, high while selected
//   bus           : spi_slave_if.slave (tx holding register, rx word, status)
//   frame_err     : only with SPI_SLAVE_FRAME_ERR_EN defined; one-cycle pulse
//                   when ss_n rises with a partially received word
// Words run back to back while ss_n stays low; a new word is loaded at the
// ss_n fall and at every trailing edge that follows bit 0.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int               DWIDTH      = 32,
    parameter bit               CPOL        = 1'b1,
    parameter int               SYNC_STAGES = 2,
    parameter logic [DWIDTH-1:0] FILL       = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_sclk,
    input  logic spi_ss_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    spi_slave_if.slave bus
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic frame_err
`endif
);
    localparam int CW = $clog2(DWIDTH);

    // ---- input conditioning ----
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
        .clk(clk), .reset(reset), .d(spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .reset(reset), .d(spi_ss_n), .rise(ss_rise), .fall(ss_fall)
    );

    // mosi is one flop younger than the edge pulses; it is stable for half an
    // SCLK period around the leading edge, so that offset is harmless.
    always_ff @(posedge clk) begin
        if (reset) mosi_sync <= '0;
        else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // ---- FSM ----
    spi_slave_state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = SHIFT;
            SHIFT:   if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state == SHIFT);
        spi_miso_oe = (state == SHIFT);
    end

    // ---- event decode ----
    logic lead, trail, in_shift, start, abort, lead_ev, trail_ev, word_done, load;
    logic [CW-1:0] bit_cnt;

    assign lead      = (CPOL == CPOL_LEAD_FALL) ? sclk_fall : sclk_rise;
    assign trail     = (CPOL == CPOL_LEAD_FALL) ? sclk_rise : sclk_fall;
    assign in_shift  = (state == SHIFT);
    assign start     = (state == IDLE) && ss_fall;
    assign abort     = in_shift && ss_rise;
    // ss_n rise wins over an SCLK edge seen in the same cycle
    assign lead_ev   = in_shift && !ss_rise && lead;
    assign trail_ev  = in_shift && !ss_rise && trail;
    assign word_done = lead_ev && (bit_cnt == '0);
    assign load      = start || (trail_ev && (bit_cnt == '0));

    // ---- tx holding register ----
    logic              hold_full;
    logic [DWIDTH-1:0] holding;
    logic              accept;
    logic [DWIDTH-1:0] load_word;
    logic              load_und;

    assign bus.tx_ready = ~hold_full;
    assign accept       = bus.tx_valid & ~hold_full;

    // A word accepted in the load cycle bypasses the holding register.
    always_comb begin
        load_word = FILL;
        load_und  = 1'b1;
        if (hold_full) begin
            load_word = holding;
            load_und  = 1'b0;
        end else if (accept) begin
            load_word = bus.tx_data;
            load_und  = 1'b0;
        end
    end

    // ---- datapath ----
    logic [DWIDTH-1:0] shift_tx, rx_sh, rx_data_q;
    logic              miso_q, rx_valid_q, underrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full  <= 1'b0;
            holding    <= '0;
            shift_tx   <= '0;
            bit_cnt    <= '0;
            rx_sh      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            rx_valid_q <= word_done;
            underrun_q <= load && load_und;

            if (load && hold_full) begin
                hold_full <= 1'b0;
            end else if (accept && !load) begin
                hold_full <= 1'b1;
                holding   <= bus.tx_data;
            end

            if (load) begin
                miso_q   <= load_word[DWIDTH-1];
                shift_tx <= load_word << 1;
                bit_cnt  <= CW'(DWIDTH - 1);
            end else if (trail_ev) begin
                miso_q   <= shift_tx[DWIDTH-1];
                shift_tx <= shift_tx << 1;
                bit_cnt  <= bit_cnt - 1'b1;
            end else if (abort) begin
                miso_q   <= 1'b0;
            end

            if (lead_ev) begin
                rx_sh <= {rx_sh[DWIDTH-2:0], mosi_s};
                if (bit_cnt == '0) rx_data_q <= {rx_sh[DWIDTH-2:0], mosi_s};
            end
        end
    end

    assign spi_miso     = miso_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.underrun = underrun_q;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    // got_bit: at least one bit of the current word has been sampled
    logic got_bit;
    always_ff @(posedge clk) begin
        if (reset) begin
            got_bit   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort && got_bit;
            if (load || abort || word_done) got_bit <= 1'b0;
            else if (lead_ev)               got_bit <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives a CPOL=1 and a CPOL=0 responder in lockstep (the CPOL=0
// SCLK is the inverse of the CPOL=1 one, mosi changes only on trailing edges).
// A word-level model (holding-register queue, FILL on empty) predicts miso
// words, received words and underrun counts per frame.
// Frames end by raising ss_n half a period after the last leading edge; SCLK
// returns to idle only after that, while the responder is already IDLE.
module tb_spi_slave;
    localparam int DW   = 32;
    localparam int HALF = 4;   // clk cycles per SCLK half period (f_clk = 8*f_sclk)
    localparam logic [DW-1:0] FILL0 = 32'hFFFF_0000;
    localparam logic [DW-1:0] FILL1 = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    logic sclk1, ss_n, mosi;
    logic sclk0;
    logic miso0, miso1, oe0, oe1;

    always #5 clk = ~clk;
    assign sclk0 = ~sclk1;

    spi_slave_if #(.DWIDTH(DW)) bus0 ();
    spi_slave_if #(.DWIDTH(DW)) bus1 ();

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic ferr0, ferr1;
`endif

    spi_slave #(.DWIDTH(DW), .CPOL(1'b0), .SYNC_STAGES(2), .FILL(FILL0)) dut0 (
        .clk(clk), .reset(reset), .spi_sclk(sclk0), .spi_ss_n(ss_n), .spi_mosi(mosi),
        .spi_miso(miso0), .spi_miso_oe(oe0), .bus(bus0.slave)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(ferr0)
`endif
    );

    spi_slave #(.DWIDTH(DW), .CPOL(1'b1), .SYNC_STAGES(2), .FILL(FILL1)) dut1 (
        .clk(clk), .reset(reset), .spi_sclk(sclk1), .spi_ss_n(ss_n), .spi_mosi(mosi),
        .spi_miso(miso1), .spi_miso_oe(oe1), .bus(bus1.slave)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(ferr1)
`endif
    );

    logic [1:0]    miso_v, oe_v, busy_v, und_v, rxv_v, rdy_v;
    logic [DW-1:0] rxd_v [2];
    assign miso_v   = {miso1, miso0};
    assign oe_v     = {oe1, oe0};
    assign busy_v   = {bus1.busy, bus0.busy};
    assign und_v    = {bus1.underrun, bus0.underrun};
    assign rxv_v    = {bus1.rx_valid, bus0.rx_valid};
    assign rdy_v    = {bus1.tx_ready, bus0.tx_ready};
    assign rxd_v[0] = bus0.rx_data;
    assign rxd_v[1] = bus1.rx_data;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---- monitors ----
    int            rx_n [2];
    int            und_n[2];
    logic [DW-1:0] rx_got[2][4];
`ifdef SPI_SLAVE_FRAME_ERR_EN
    int            ferr_n[2];
    always @(negedge clk) begin
        if (ferr0) ferr_n[0]++;
        if (ferr1) ferr_n[1]++;
    end
`endif

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rxv_v[d]) begin
                if (rx_n[d] < 4) rx_got[d][rx_n[d]] = rxd_v[d];
                rx_n[d]++;
            end
            if (und_v[d]) und_n[d]++;
        end
    end

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            rx_n[d]  = 0;
            und_n[d] = 0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            ferr_n[d] = 0;
`endif
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---- model state and per-frame stimulus ----
    logic [DW-1:0] hold_q[$];
    logic [DW-1:0] tx_w[4];
    bit            tx_push[4];
    logic [DW-1:0] mo_w[4];

    task automatic push(input logic [DW-1:0] w);
        for (int d = 0; d < 2; d++) chk($sformatf("cpol%0d_tx_ready", d), rdy_v[d], 1'b1);
        bus0.tx_valid = 1'b1; bus1.tx_valid = 1'b1;
        bus0.tx_data  = w;    bus1.tx_data  = w;
        wait_clk(1);
        bus0.tx_valid = 1'b0; bus1.tx_valid = 1'b0;
        for (int d = 0; d < 2; d++) chk($sformatf("cpol%0d_tx_ready_drop", d), rdy_v[d], 1'b0);
        hold_q.push_back(w);
    endtask

    task automatic chk_reset_vals(input string where);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_cpol%0d_miso", where, d),     miso_v[d], 1'b0);
            chk($sformatf("%s_cpol%0d_oe", where, d),       oe_v[d],   1'b0);
            chk($sformatf("%s_cpol%0d_busy", where, d),     busy_v[d], 1'b0);
            chk($sformatf("%s_cpol%0d_tx_ready", where, d), rdy_v[d],  1'b1);
            chk($sformatf("%s_cpol%0d_rx_valid", where, d), rxv_v[d],  1'b0);
            chk($sformatf("%s_cpol%0d_rx_data", where, d),  rxd_v[d],  '0);
            chk($sformatf("%s_cpol%0d_underrun", where, d), und_v[d],  1'b0);
        end
    endtask

    // nw words in the frame; nbits < nw*DW aborts the last word; reset pulse
    // after leading edge number rst_at (-1: none).
    task automatic run_frame(input int nw, input int nbits, input int rst_at);
        logic [DW-1:0] exp_w[2][4];
        logic [DW-1:0] got_w[2][4];
        logic [DW-1:0] ones, mask, t;
        int            exp_und, nfull, nstart, nb, w, i;
        bit            was_reset;
        ones = '1; exp_und = 0; was_reset = 0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin got_w[d][k] = '0; exp_w[d][k] = '0; end
        clear_counts();
        if (tx_push[0]) push(tx_w[0]);
        wait_clk(4);
        ss_n = 1'b0;
        wait_clk(2 * HALF);
        chk("frame_busy", busy_v, 2'b11);
        chk("frame_oe", oe_v, 2'b11);
        for (int b = 0; b < nbits; b++) begin
            w = b / DW;
            i = DW - 1 - (b % DW);
            if (b % DW == 0 && !was_reset) begin
                if (hold_q.size() > 0) begin
                    t = hold_q.pop_front();
                    exp_w[0][w] = t; exp_w[1][w] = t;
                end else begin
                    exp_w[0][w] = FILL0; exp_w[1][w] = FILL1;
                    exp_und++;
                end
            end
            mosi = mo_w[w][i];
            wait_clk(HALF);
            got_w[0][w][i] = miso_v[0];
            got_w[1][w][i] = miso_v[1];
            sclk1 = 1'b0;              // leading edge for both polarities
            wait_clk(HALF);
            if (b == rst_at) begin
                reset = 1'b1;
                wait_clk(2);
                reset = 1'b0;
                was_reset = 1;
                hold_q.delete();
                chk_reset_vals("midreset");
                clear_counts();
            end
            if (b % DW == 4 && w + 1 < nw && tx_push[w+1] && !was_reset) push(tx_w[w+1]);
            if (b != nbits - 1) sclk1 = 1'b1;  // trailing edge
        end
        ss_n = 1'b1;
        wait_clk(HALF);
        sclk1 = 1'b1;
        mosi  = 1'b0;
        wait_clk(8);

        nfull  = nbits / DW;
        nstart = (nbits + DW - 1) / DW;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("cpol%0d_busy_after", d), busy_v[d], 1'b0);
            chk($sformatf("cpol%0d_oe_after", d),   oe_v[d],   1'b0);
            chk($sformatf("cpol%0d_miso_after", d), miso_v[d], 1'b0);
            if (was_reset) begin
                chk($sformatf("cpol%0d_rst_rx_cnt", d), rx_n[d],   0);
                chk($sformatf("cpol%0d_rst_und", d),    und_n[d],  0);
                chk($sformatf("cpol%0d_rst_rxd", d),    rxd_v[d],  '0);
            end else begin
                for (int k = 0; k < nstart; k++) begin
                    nb   = (k < nfull) ? DW : (nbits % DW);
                    mask = ones << (DW - nb);
                    chk($sformatf("cpol%0d_miso_w%0d", d, k), got_w[d][k] & mask, exp_w[d][k] & mask);
                end
                chk($sformatf("cpol%0d_rx_cnt", d), rx_n[d], nfull);
                for (int k = 0; k < nfull && k < 4; k++)
                    chk($sformatf("cpol%0d_rx_w%0d", d, k), rx_got[d][k], mo_w[k]);
                if (nfull > 0) chk($sformatf("cpol%0d_rx_held", d), rxd_v[d], mo_w[nfull-1]);
                chk($sformatf("cpol%0d_underrun_cnt", d), und_n[d], exp_und);
            end
`ifdef SPI_SLAVE_FRAME_ERR_EN
            chk($sformatf("cpol%0d_frame_err", d), ferr_n[d], (!was_reset && (nbits % DW) != 0) ? 1 : 0);
`endif
        end
    endtask

    task automatic set_words(input logic [DW-1:0] t0, input bit p0, input logic [DW-1:0] m0);
        for (int k = 0; k < 4; k++) begin
            tx_w[k] = $urandom; mo_w[k] = $urandom; tx_push[k] = 0;
        end
        tx_w[0] = t0; tx_push[0] = p0; mo_w[0] = m0;
    endtask

    initial begin
        int nw, nbits;
        reset = 1'b1; sclk1 = 1'b1; ss_n = 1'b1; mosi = 1'b0;
        bus0.tx_valid = 1'b0; bus1.tx_valid = 1'b0;
        bus0.tx_data  = '0;   bus1.tx_data  = '0;
        clear_counts();
        wait_clk(4);
        reset = 1'b0;
        wait_clk(1);
        chk_reset_vals("reset");
        wait_clk(4);

        // known word exchange
        set_words(32'hA5A5_0F0F, 1, 32'h1234_5678);
        run_frame(1, DW, -1);

        // holding empty: FILL goes out, one underrun
        set_words($urandom, 0, $urandom);
        run_frame(1, DW, -1);

        // burst of two words, second pushed during the first
        set_words($urandom, 1, $urandom);
        tx_push[1] = 1;
        run_frame(2, 2 * DW, -1);

        // abort after 10 bits
        set_words($urandom, 1, $urandom);
        run_frame(1, 10, -1);

        // reset after 16 bits, then a fresh frame
        set_words(32'h1111_2222, 1, $urandom);
        run_frame(1, DW, 15);
        set_words(32'hDEAD_BEEF, 1, $urandom);
        run_frame(1, DW, -1);

        // randomized frames
        for (int r = 0; r < 8; r++) begin
            set_words($urandom, bit'($urandom_range(0, 3) != 0), $urandom);
            nw = $urandom_range(1, 3);
            for (int k = 1; k < 4; k++) tx_push[k] = ($urandom_range(0, 3) != 0);
            nbits = nw * DW;
            if ($urandom_range(0, 3) == 0) nbits = nbits - $urandom_range(1, DW - 1);
            run_frame(nw, nbits, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
